// File: rtl/mux8_rr_collector.sv
// Eight-channel round-robin collector: merges eight valid/ready streams into one
// registered output stream tagged with the 3-bit source channel index.
module mux8_rr_collector #(
    parameter int unsigned DW = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [7:0]      in_valid_i,
    input  logic [8*DW-1:0] in_data_i,
    output logic [7:0]      in_ready_o,
    output logic            out_valid_o,
    output logic [2:0]      out_sel_o,
    output logic [DW-1:0]   out_data_o,
    input  logic            out_ready_i
);

    logic            out_valid_q, out_valid_d;
    logic [2:0]      out_sel_q, out_sel_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [2:0]      ptr_q, ptr_d;

    logic            load;
    logic            grant_valid;
    logic [2:0]      grant_idx;
    logic [DW-1:0]   ch_data [8];

    for (genvar i = 0; i < 8; i++) begin : g_unpack
        assign ch_data[i] = in_data_i[i*DW +: DW];
    end

    assign load = ~out_valid_q | out_ready_i;

    // Search starts at ptr_q and wraps, so the channel after the last grant has priority.
    always_comb begin
        logic [2:0] idx;
        grant_valid = 1'b0;
        grant_idx   = 3'd0;
        idx         = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!grant_valid && in_valid_i[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    always_comb begin
        in_ready_o = 8'h00;
        if (rst_ni && load && grant_valid) begin
            in_ready_o = 8'b1 << grant_idx;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        out_data_d  = out_data_q;
        ptr_d       = ptr_q;
        if (load) begin
            if (grant_valid) begin
                out_valid_d = 1'b1;
                out_sel_d   = grant_idx;
                out_data_d  = ch_data[grant_idx];
                ptr_d       = grant_idx + 3'd1;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid_q <= 1'b0;
            out_sel_q   <= 3'd0;
            out_data_q  <= '0;
            ptr_q       <= 3'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            out_data_q  <= out_data_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_sel_o   = out_sel_q;
    assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_mux8_rr_collector.sv
// Directed bench for mux8_rr_collector: expected words queued by the stimulus,
// popped and compared by a negedge monitor whenever the output handshakes.
module tb_mux8_rr_collector;

    localparam int unsigned DW = 8;

    logic            clk;
    logic            rst_n;
    logic [7:0]      in_valid;
    logic [8*DW-1:0] in_data;
    logic [7:0]      in_ready;
    logic            out_valid;
    logic [2:0]      out_sel;
    logic [DW-1:0]   out_data;
    logic            out_ready;

    logic [DW-1:0]   ch_val [8];
    logic [10:0]     exp_q [$];

    logic            chk_rdy;
    logic [7:0]      exp_rdy;
    logic            chk_out;
    logic [11:0]     exp_out;
    logic            done;

    int              n_vec;
    int              n_err;

    mux8_rr_collector #(.DW(DW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_sel_o   (out_sel),
        .out_data_o  (out_data),
        .out_ready_i (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 8; i++) in_data[i*DW +: DW] = ch_val[i];
    end

    // Apply the current inputs/expectations for one cycle; the monitor samples at negedge.
    task automatic step(input logic cr, input logic [7:0] er,
                        input logic co, input logic ov, input logic [2:0] os,
                        input logic [7:0] od);
        chk_rdy = cr;
        exp_rdy = er;
        chk_out = co;
        exp_out = {ov, os, od};
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] sel, input logic [7:0] data);
        exp_q.push_back({sel, data});
    endtask

    // Monitor: all comparisons and counters live here.
    initial begin
        logic [10:0] e;
        bit done_seen;
        n_vec = 0;
        n_err = 0;
        done_seen = 0;
        forever begin
            @(negedge clk);
            if (chk_rdy) begin
                n_vec++;
                if (in_ready !== exp_rdy) begin
                    n_err++;
                    $display("FAIL in_ready @%0t: got %h want %h", $time, in_ready, exp_rdy);
                end
            end
            if (chk_out) begin
                n_vec++;
                if ({out_valid, out_sel, out_data} !== exp_out) begin
                    n_err++;
                    $display("FAIL out_state @%0t: got v=%b s=%0d d=%h want v=%b s=%0d d=%h",
                             $time, out_valid, out_sel, out_data,
                             exp_out[11], exp_out[10:8], exp_out[7:0]);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word @%0t: got s=%0d d=%h want none",
                             $time, out_sel, out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_sel, out_data} !== e) begin
                        n_err++;
                        $display("FAIL out_word @%0t: got s=%0d d=%h want s=%0d d=%h",
                                 $time, out_sel, out_data, e[10:8], e[7:0]);
                    end
                end
            end
            if (done && !done_seen) begin
                done_seen = 1;
                n_vec++;
                if (exp_q.size() != 0) begin
                    n_err++;
                    $display("FAIL missing_words: got %0d left want 0", exp_q.size());
                end
            end
        end
    end

    initial begin
        done      = 1'b0;
        chk_rdy   = 1'b0;
        chk_out   = 1'b0;
        exp_rdy   = 8'h00;
        exp_out   = '0;
        rst_n     = 1'b0;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) ch_val[i] = 8'h10 + 8'(i);
        @(posedge clk);
        #1;

        // Reset held with every channel requesting.
        for (int i = 0; i < 3; i++) step(1, 8'h00, 1, 1'b0, 3'd0, 8'h00);

        // Release, then full rotation: grants 0..7,0,1.
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            push(3'(k % 8), 8'h10 + 8'(k % 8));
            step(1, 8'b1 << (k % 8), 0, 1'b0, 3'd0, 8'h00);
        end

        // Single channel 5 (ptr was 2).
        in_valid  = 8'h20;
        ch_val[5] = 8'hA5;
        push(3'd5, 8'hA5);
        step(1, 8'h20, 0, 1'b0, 3'd0, 8'h00);

        // ptr=6, channels 0 and 3: 0 first, then 3.
        in_valid = 8'h09;
        push(3'd0, 8'h10);
        step(1, 8'h01, 1, 1'b1, 3'd5, 8'hA5);
        push(3'd3, 8'h13);
        step(1, 8'h08, 1, 1'b1, 3'd0, 8'h10);
        in_valid = 8'h00;
        step(1, 8'h00, 1, 1'b1, 3'd3, 8'h13);
        // Empty load: valid drops, sel/data hold; ptr=4 so channel 4 wins next.
        in_valid = 8'hFF;
        push(3'd4, 8'h14);
        step(1, 8'h10, 1, 1'b0, 3'd3, 8'h13);

        // Backpressure with channel 2 held.
        in_valid = 8'h04;
        push(3'd2, 8'h12);
        step(1, 8'h04, 1, 1'b1, 3'd4, 8'h14);
        in_valid  = 8'hFF;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 8'h00, 1, 1'b1, 3'd2, 8'h12);
        out_ready = 1'b1;
        push(3'd3, 8'h13);
        step(1, 8'h08, 1, 1'b1, 3'd2, 8'h12);
        in_valid = 8'h00;
        step(1, 8'h00, 1, 1'b1, 3'd3, 8'h13);

        // Reset mid-stall: held channel-1 word must never emerge.
        in_valid = 8'h02;
        step(1, 8'h02, 1, 1'b0, 3'd3, 8'h13);
        in_valid  = 8'h00;
        out_ready = 1'b0;
        step(1, 8'h00, 1, 1'b1, 3'd1, 8'h11);
        rst_n    = 1'b0;
        in_valid = 8'hFF;
        step(1, 8'h00, 1, 1'b1, 3'd1, 8'h11);
        rst_n     = 1'b1;
        in_valid  = 8'h00;
        out_ready = 1'b1;
        step(1, 8'h00, 1, 1'b0, 3'd0, 8'h00);
        // ptr back at 0: channel 0 beats channel 7.
        in_valid = 8'h81;
        push(3'd0, 8'h10);
        step(1, 8'h01, 1, 1'b0, 3'd0, 8'h00);
        in_valid = 8'h00;
        step(1, 8'h00, 1, 1'b1, 3'd0, 8'h10);
        step(1, 8'h00, 1, 1'b0, 3'd0, 8'h10);

        chk_rdy = 1'b0;
        chk_out = 1'b0;
        done    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux8_rr_collector.md
# mux8_rr_collector

Eight-channel round-robin collector: merges eight independent valid/ready input streams onto one registered output stream tagged with a 3-bit source index. It is the gathering counterpart of our 1-to-8 demultiplexer, and sits upstream of any block that needs a single serialized stream carrying an `s`-style channel tag. The output stage is a one-entry holding register with full backpressure, sustaining one transfer per cycle.

## Interface
- `DW`, default 8: data width per channel.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid` input 8: bit i is high when channel i presents data.
- `in_data` input 8*DW: channel i data in bits [i*DW +: DW].
- `in_ready` output 8: bit i is high when channel i is accepted this cycle. At most one bit is high.
- `out_valid` output 1: holding register contains a word.
- `out_sel` output 3: source channel index of the held word (0..7).
- `out_data` output DW: held word.
- `out_ready` input 1: downstream accepts the held word this cycle.

## Operation
- State:
  - holding register (`out_valid`, `out_sel`, `out_data`);
  - round-robin pointer `ptr[2:0]`, the highest-priority channel for the next grant.
- Load enable: `load = ~out_valid | out_ready`. The register is empty, or is being drained this cycle.
- Arbitration (combinational):
  - Search channels `ptr`, `ptr+1`, …, `ptr+7` (mod 8) and grant the first one with `in_valid` high.
  - `in_ready[g] = load & in_valid[g]` for the granted g. All other bits are 0.
  - `in_ready` depends combinationally on `in_valid` and `out_ready`.
- On a rising edge with `load` high and a grant g:
  - `out_valid <= 1`, `out_sel <= g`, `out_data <= in_data[g]`;
  - `ptr <= g+1` (mod 8; 7 wraps to 0).
- On a rising edge with `load` high and no requester: `out_valid <= 0`. `out_sel`, `out_data` and `ptr` hold.
- On a rising edge with `load` low (`out_valid=1`, `out_ready=0`): all state holds. `out_sel` and `out_data` must stay stable while stalled.
- A channel is transferred only when its `in_valid` and `in_ready` are both high in the same cycle. A channel that drops `in_valid` before it is granted is simply skipped; no error is raised.
- Fairness:
  - With all eight channels continuously valid and `out_ready=1`, the grant order is 0,1,…,7,0,… .
  - A continuously requesting channel waits at most 7 transfers.
- Reset (`rst_n=0` at an edge):
  - `out_valid=0`, `out_sel=0`, `out_data=0`, `ptr=0`.
  - `in_ready` is forced to 0 in any cycle where `rst_n=0`.
  - A held word is discarded when reset is asserted mid-stall.

## Timing
- Latency: a word accepted on edge N (`in_valid[i] & in_ready[i]` high before edge N) appears on `out_*` immediately after edge N. That is 1 cycle.
- Throughput: one word per cycle while `out_ready=1` and at least one channel is valid. There are no bubbles on simultaneous drain and refill.
- Backpressure: while `out_ready=0` and `out_valid=1`, `in_ready` is all zeros within the same cycle.
- Simultaneous drain and load: the old word leaves and the new word is captured on the same edge.
- The first grant after reset goes to the lowest-index valid channel, because `ptr=0`.

## Test plan
- Reset: hold `rst_n=0` for 3 cycles with all `in_valid=8'hFF` -> `in_ready=0`, `out_valid=0`, `out_sel=0`, `out_data=0`. On the first cycle after release, channel 0 is granted.
- Single channel: `in_valid=8'h20`, `in_data` channel 5 = 8'hA5, `out_ready=1` -> `in_ready=8'h20`. Next cycle `out_valid=1`, `out_sel=5`, `out_data=8'hA5`. `ptr` becomes 6.
- Full rotation: `in_valid=8'hFF`, channel i data = 8'h10+i, `out_ready=1` for 10 cycles -> `out_sel` sequence 0,1,…,7,0,1, and each `out_data` matches its source. `ptr` wraps from 7 to 0.
- Backpressure: with a word from channel 2 held, drive `out_ready=0` for 4 cycles -> `in_ready=0`, and `out_sel=2` and `out_data` stay stable. When `out_ready` goes to 1, the held word drains and the next grant is loaded on the same edge, with no idle cycle.
- Skip and priority: `ptr=6`, `in_valid=8'h09` (channels 0 and 3) -> channel 0 is granted first, then 3. `ptr` ends at 4.
- Reset mid-stall: `out_valid=1`, `out_ready=0`, then pulse `rst_n=0` for 1 cycle -> `out_valid=0` and `ptr=0` after the edge. The held word is never emitted.
